alu_design: RTL and testbench

ALU_DESIGN -- requirements
Module: alu_design

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_design.sv | 135 +++++++++++++
 tb/tb_alu_design.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, command encodings and operand-valid codes for alu_design
package alu_pkg;
    localparam int DW_DEF = 8;
    localparam int CW_DEF = 4;
    typedef enum logic [3:0] {
        ADD, SUB, ADD_CIN, SUB_CIN, INC_A, DEC_A, INC_B, DEC_B, CMP, MUL_INC, MUL_SHL
    } arith_cmd_e;
    typedef enum logic [3:0] {
        AND, NAND, OR, NOR, XOR, XNOR, NOT_A, NOT_B,
        SHR1_A, SHL1_A, SHR1_B, SHL1_B, ROL_A_B, ROR_A_B
    } logic_cmd_e;
    localparam logic [1:0] IV_NONE = 2'b00;
    localparam logic [1:0] IV_A    = 2'b01;
    localparam logic [1:0] IV_B    = 2'b10;
    localparam logic [1:0] IV_AB   = 2'b11;
endpackage

// File: rtl/alu_design.sv
// alu_design: registered arithmetic/logical ALU with a two-stage multiply path
// Ports: CLK, RST (async, active-low), CE (clock enable), MODE (1 arith / 0 logic),
//        CMD (operation), INP_VALID ({B valid, A valid}), OPA/OPB (operands), CIN,
//        RES (zero-extended result), COUT, OFLOW (borrow), G/E/L (compare), ERR.
// CW must be at least 4; command bits above bit 3 must be zero for a legal command.
module alu_design
    import alu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CE,
    input  logic            MODE,
    input  logic [CW-1:0]   CMD,
    input  logic [1:0]      INP_VALID,
    input  logic [DW-1:0]   OPA,
    input  logic [DW-1:0]   OPB,
    input  logic            CIN,
    output logic [2*DW-1:0] RES,
    output logic            COUT,
    output logic            OFLOW,
    output logic            G,
    output logic            E,
    output logic            L,
    output logic            ERR
);
    localparam int SW = $clog2(DW);
    localparam logic [DW:0] ONE = {{DW{1'b0}}, 1'b1};
    logic [3:0]      op;
    logic [DW:0]     a9, b9, c9, t, ma, mb, ma_q, mb_q;
    logic [DW-1:0]   r;
    logic [2*DW-1:0] p;
    logic [1:0]      need;
    logic            legal, cy, bw, g, e, l, mul, bad, mul_go, mul_pend;
    int              amt;
    assign op  = CMD[3:0];
    assign a9  = {1'b0, OPA};
    assign b9  = {1'b0, OPB};
    assign c9  = {{DW{1'b0}}, CIN};
    assign amt = int'(OPB[SW-1:0]);
    // Sums and differences are DW+1 wide so bit DW is the carry or the borrow.
    always_comb begin
        t = '0;
        r = '0;
        cy = 1'b0;
        bw = 1'b0;
        g = 1'b0;
        e = 1'b0;
        l = 1'b0;
        need = IV_AB;
        legal = 1'b1;
        mul = 1'b0;
        ma = '0;
        mb = '0;
        if (MODE) begin
            case (op)
                ADD:     begin t = a9 + b9; cy = t[DW]; end
                SUB:     begin t = a9 - b9; bw = t[DW]; end
                ADD_CIN: begin t = a9 + b9 + c9; cy = t[DW]; end
                SUB_CIN: begin t = a9 - b9 - c9; bw = t[DW]; end
                INC_A:   begin t = a9 + ONE; cy = t[DW]; need = IV_A; end
                DEC_A:   begin t = a9 - ONE; bw = t[DW]; need = IV_A; end
                INC_B:   begin t = b9 + ONE; cy = t[DW]; need = IV_B; end
                DEC_B:   begin t = b9 - ONE; bw = t[DW]; need = IV_B; end
                CMP:     begin g = OPA > OPB; e = OPA == OPB; l = OPA < OPB; end
                MUL_INC: begin mul = 1'b1; ma = a9 + ONE; mb = b9 + ONE; end
                MUL_SHL: begin mul = 1'b1; ma = {OPA, 1'b0}; mb = b9; end
                default: legal = 1'b0;
            endcase
            r = t[DW-1:0];
        end else begin
            case (op)
                AND:     r = OPA & OPB;
                NAND:    r = ~(OPA & OPB);
                OR:      r = OPA | OPB;
                NOR:     r = ~(OPA | OPB);
                XOR:     r = OPA ^ OPB;
                XNOR:    r = ~(OPA ^ OPB);
                NOT_A:   begin r = ~OPA; need = IV_A; end
                NOT_B:   begin r = ~OPB; need = IV_B; end
                SHR1_A:  begin r = OPA >> 1; need = IV_A; end
                SHL1_A:  begin r = OPA << 1; need = IV_A; end
                SHR1_B:  begin r = OPB >> 1; need = IV_B; end
                SHL1_B:  begin r = OPB << 1; need = IV_B; end
                ROL_A_B: begin r = (OPA << amt) | (OPA >> (DW - amt)); legal = ~|(OPB >> SW); end
                ROR_A_B: begin r = (OPA >> amt) | (OPA << (DW - amt)); legal = ~|(OPB >> SW); end
                default: legal = 1'b0;
            endcase
        end
    end
    assign bad    = !legal || |(CMD >> 4) || (INP_VALID & need) != need;
    assign mul_go = mul && !bad;
    assign p      = {{(DW-1){1'b0}}, ma_q} * {{(DW-1){1'b0}}, mb_q};
    // A sampled command always replaces a pending multiply; an idle edge lets it complete.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RES <= '0;
            COUT <= 1'b0;
            OFLOW <= 1'b0;
            G <= 1'b0;
            E <= 1'b0;
            L <= 1'b0;
            ERR <= 1'b0;
            mul_pend <= 1'b0;
            ma_q <= '0;
            mb_q <= '0;
        end else if (CE) begin
            if (INP_VALID != IV_NONE) begin
                mul_pend <= mul_go;
                ma_q <= ma;
                mb_q <= mb;
                if (!mul_go) begin
                    RES <= bad ? '0 : {{DW{1'b0}}, r};
                    COUT <= cy && !bad;
                    OFLOW <= bw && !bad;
                    G <= g && !bad;
                    E <= e && !bad;
                    L <= l && !bad;
                    ERR <= bad;
                end
            end else if (mul_pend) begin
                RES <= p;
                COUT <= 1'b0;
                OFLOW <= 1'b0;
                G <= 1'b0;
                E <= 1'b0;
                L <= 1'b0;
                ERR <= 1'b0;
                mul_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_design.sv
// tb_alu_design: directed and randomized scoreboard bench for alu_design
module tb_alu_design;
    import alu_pkg::*;
    typedef struct packed {
        logic [15:0] res;
        logic        cout, oflow, g, e, l, err;
    } exp_t;
    logic        CLK = 1'b0;
    logic        RST, CE, MODE, CIN;
    logic [3:0]  CMD;
    logic [1:0]  INP_VALID;
    logic [7:0]  OPA, OPB;
    logic [15:0] RES;
    logic        COUT, OFLOW, G, E, L, ERR;
    exp_t        q[$];
    exp_t        last;
    int          vecs = 0;
    int          miss = 0;
    localparam exp_t Z = '0;
    alu_design #(.DW(8), .CW(4)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD), .INP_VALID(INP_VALID),
        .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES), .COUT(COUT), .OFLOW(OFLOW),
        .G(G), .E(E), .L(L), .ERR(ERR)
    );
    always #5 CLK = ~CLK;
    function automatic exp_t mk(logic [15:0] r, logic c, logic o, logic g, logic e, logic l, logic er);
        mk = '{r, c, o, g, e, l, er};
    endfunction
    function automatic exp_t model(logic m, logic [3:0] c, logic [1:0] iv, logic [7:0] a, logic [7:0] b, logic ci);
        exp_t x;
        int s;
        logic [7:0] r;
        logic [1:0] need;
        bit ok;
        x = '0;
        s = 0;
        r = a;
        need = 2'b11;
        ok = 1;
        if (m) begin
            case (c)
                0: begin s = int'(a) + int'(b); x.cout = s > 255; end
                1: begin s = int'(a) - int'(b); x.oflow = s < 0; end
                2: begin s = int'(a) + int'(b) + int'(ci); x.cout = s > 255; end
                3: begin s = int'(a) - int'(b) - int'(ci); x.oflow = s < 0; end
                4: begin s = int'(a) + 1; x.cout = s > 255; need = 2'b01; end
                5: begin s = int'(a) - 1; x.oflow = s < 0; need = 2'b01; end
                6: begin s = int'(b) + 1; x.cout = s > 255; need = 2'b10; end
                7: begin s = int'(b) - 1; x.oflow = s < 0; need = 2'b10; end
                8: begin x.g = a > b; x.e = a == b; x.l = a < b; end
                default: ok = 0;
            endcase
            x.res = 16'(s & 255);
        end else begin
            case (c)
                0: r = a & b;
                1: r = ~(a & b);
                2: r = a | b;
                3: r = ~(a | b);
                4: r = a ^ b;
                5: r = ~(a ^ b);
                6: begin r = ~a; need = 2'b01; end
                7: begin r = ~b; need = 2'b10; end
                8: begin r = {1'b0, a[7:1]}; need = 2'b01; end
                9: begin r = {a[6:0], 1'b0}; need = 2'b01; end
                10: begin r = {1'b0, b[7:1]}; need = 2'b10; end
                11: begin r = {b[6:0], 1'b0}; need = 2'b10; end
                12: begin repeat (int'(b[2:0])) r = {r[6:0], r[7]}; ok = b[7:3] == 0; end
                13: begin repeat (int'(b[2:0])) r = {r[0], r[7:1]}; ok = b[7:3] == 0; end
                default: ok = 0;
            endcase
            x.res = {8'h00, r};
        end
        if (!ok || (iv & need) != need) x = mk(16'h0000, 0, 0, 0, 0, 0, 1);
        return x;
    endfunction
    task automatic push(input exp_t x);
        q.push_back(x);
        last = x;
    endtask
    task automatic apply(input logic m, input logic [3:0] c, input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b, input logic ci);
        MODE = m;
        CMD = c;
        INP_VALID = iv;
        OPA = a;
        OPB = b;
        CIN = ci;
        @(posedge CLK);
        @(negedge CLK);
    endtask
    task automatic check(input string tag);
        exp_t x, o;
        vecs++;
        if (q.size() == 0) begin
            miss++;
            $error("FAIL %s: scoreboard empty", tag);
            return;
        end
        x = q.pop_front();
        o = {RES, COUT, OFLOW, G, E, L, ERR};
        assert (o === x) else begin
            miss++;
            $error("FAIL %s: observed res=%h cout=%b oflow=%b gel=%b%b%b err=%b, expected res=%h cout=%b oflow=%b gel=%b%b%b err=%b",
                   tag, o.res, o.cout, o.oflow, o.g, o.e, o.l, o.err, x.res, x.cout, x.oflow, x.g, x.e, x.l, x.err);
        end
    endtask
    initial begin
        RST = 1'b0;
        CE = 1'b0;
        MODE = 1'b0;
        CMD = '0;
        INP_VALID = IV_NONE;
        OPA = '0;
        OPB = '0;
        CIN = 1'b0;
        repeat (2) @(negedge CLK);
        push(Z); check("reset");
        RST = 1'b1;
        CE = 1'b1;
        push(mk(16'h0000, 1, 0, 0, 0, 0, 0)); apply(1, ADD, IV_AB, 8'hFF, 8'h01, 0); check("add_carry");
        push(mk(16'h00FE, 0, 1, 0, 0, 0, 0)); apply(1, SUB, IV_AB, 8'h03, 8'h05, 0); check("sub_borrow");
        push(mk(16'h0000, 0, 0, 0, 1, 0, 0)); apply(1, CMP, IV_AB, 8'h55, 8'h55, 0); check("cmp_eq");
        push(mk(16'h0000, 0, 0, 1, 0, 0, 0)); apply(1, CMP, IV_AB, 8'h60, 8'h55, 0); check("cmp_gt");
        push(mk(16'h0000, 0, 0, 0, 0, 1, 0)); apply(1, CMP, IV_AB, 8'h10, 8'h55, 0); check("cmp_lt");
        push(mk(16'h00FF, 0, 1, 0, 0, 0, 0)); apply(1, DEC_A, IV_A, 8'h00, 8'h77, 0); check("dec_a_zero");
        push(mk(16'h0000, 1, 0, 0, 0, 0, 0)); apply(1, INC_B, IV_B, 8'h12, 8'hFF, 0); check("inc_b_wrap");
        push(mk(16'h0020, 0, 0, 0, 0, 0, 0)); apply(1, ADD_CIN, IV_AB, 8'h0F, 8'h10, 1); check("add_cin");
        push(mk(16'h0000, 0, 0, 0, 0, 0, 1)); apply(1, ADD, IV_A, 8'h01, 8'h01, 0); check("add_missing_b");
        push(mk(16'h0000, 0, 0, 0, 0, 0, 1)); apply(1, 4'd11, IV_AB, 8'h01, 8'h01, 0); check("arith_range");
        push(mk(16'h0000, 0, 0, 0, 0, 0, 1)); apply(0, 4'd14, IV_AB, 8'h01, 8'h01, 0); check("logic_range");
        push(mk(16'h0003, 0, 0, 0, 0, 0, 0)); apply(0, ROL_A_B, IV_AB, 8'h81, 8'h01, 0); check("rol");
        push(mk(16'h0000, 0, 0, 0, 0, 0, 1)); apply(0, ROL_A_B, IV_AB, 8'h81, 8'h10, 0); check("rol_bad_amt");
        push(mk(16'h00C0, 0, 0, 0, 0, 0, 0)); apply(0, ROR_A_B, IV_AB, 8'h81, 8'h01, 0); check("ror");
        push(last); apply(1, ADD, IV_NONE, 8'h33, 8'h44, 0); check("idle_hold");
        push(last); apply(1, MUL_INC, IV_AB, 8'h02, 8'h03, 0); check("mul_inc_stage1");
        push(mk(16'h000C, 0, 0, 0, 0, 0, 0)); apply(1, ADD, IV_NONE, 8'h00, 8'h00, 0); check("mul_inc_result");
        push(last); apply(1, MUL_SHL, IV_AB, 8'h03, 8'h05, 0); check("mul_shl_stage1");
        push(mk(16'h001E, 0, 0, 0, 0, 0, 0)); apply(1, ADD, IV_NONE, 8'h00, 8'h00, 0); check("mul_shl_result");
        push(last); apply(1, MUL_INC, IV_AB, 8'h04, 8'h04, 0); check("mul_ce_stage1");
        CE = 1'b0;
        push(last); apply(1, ADD, IV_AB, 8'h01, 8'h01, 0); check("ce_freeze");
        CE = 1'b1;
        push(mk(16'h0019, 0, 0, 0, 0, 0, 0)); apply(1, ADD, IV_NONE, 8'h00, 8'h00, 0); check("mul_resume");
        push(last); apply(1, MUL_INC, IV_AB, 8'h02, 8'h03, 0); check("override_stage1");
        push(mk(16'h0003, 0, 0, 0, 0, 0, 0)); apply(1, ADD, IV_AB, 8'h01, 8'h02, 0); check("override_new");
        push(last); apply(1, ADD, IV_NONE, 8'h00, 8'h00, 0); check("override_hold");
        push(last); apply(1, MUL_INC, IV_AB, 8'h05, 8'h05, 0); check("rst_mul_stage1");
        RST = 1'b0;
        #1;
        push(Z); check("rst_async");
        @(negedge CLK);
        RST = 1'b1;
        push(Z); apply(1, ADD, IV_NONE, 8'h00, 8'h00, 0); check("rst_pipe_clear");
        for (int i = 0; i < 24; i++) begin
            logic m;
            logic [3:0] c;
            logic [1:0] iv;
            logic [7:0] a, b;
            logic ci;
            m = 1'($urandom_range(0, 1));
            c = 4'($urandom_range(0, 15));
            if (m && (c == 4'd9 || c == 4'd10)) c = 4'd0;
            iv = 2'($urandom_range(1, 3));
            a = 8'($urandom);
            b = 8'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom);
            ci = 1'($urandom_range(0, 1));
            push(model(m, c, iv, a, b, ci));
            apply(m, c, iv, a, b, ci);
            check($sformatf("rand%0d_m%0d_c%0d", i, m, c));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
